cache_fill_ctrl: RTL and testbench

Request-side controller sitting directly upstream of the K-way clock-replacement cache. Accepts one line-read request at a time over a valid/ready handshake and probes the cache read port. On a hit it returns the cached line; on a miss it fetches the line from backing memory, writes it into the cache through the write port, then returns it. A memory timeout is reported to the requester as an error response.

---
 rtl/cache_fill_ctrl_if.sv | 64 ++++++
 rtl/cache_fill_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl_if
//
// Purpose: bundles every bus signal around cache_fill_ctrl: the requester
// handshake, the cache read/write port and the backing-memory port.
//
// Modports:
//   master : the controller view. It drives req_ready, the response, the cache
//            address/data/strobes and the memory request.
//   slave  : the environment view (requester + cache + memory), the mirror
//            image of master.
//
// Signal summary:
//   req_valid/req_ready/req_addr   request handshake
//   rsp_valid/rsp_data/rsp_err     one-cycle response strobe, no backpressure
//   c_addr/c_val/c_read/c_write    cache port driven by the controller
//   c_hit/c_out_val                cache flags/data, registered by the cache
//   mem_req/mem_addr               level-held memory read request
//   mem_ack/mem_data               one-cycle ack with data in the same cycle
// -----------------------------------------------------------------------------
interface cache_fill_ctrl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int LINE_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;

   logic                  rsp_valid;
   logic [LINE_WIDTH-1:0] rsp_data;
   logic                  rsp_err;

   logic [ADDR_WIDTH-1:0] c_addr;
   logic [LINE_WIDTH-1:0] c_val;
   logic                  c_read;
   logic                  c_write;
   logic                  c_hit;
   logic [LINE_WIDTH-1:0] c_out_val;

   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [LINE_WIDTH-1:0] mem_data;

   modport master (
      input  req_valid, req_addr,
      output req_ready,
      output rsp_valid, rsp_data, rsp_err,
      output c_addr, c_val, c_read, c_write,
      input  c_hit, c_out_val,
      output mem_req, mem_addr,
      input  mem_ack, mem_data
   );

   modport slave (
      output req_valid, req_addr,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_err,
      input  c_addr, c_val, c_read, c_write,
      output c_hit, c_out_val,
      input  mem_req, mem_addr,
      output mem_ack, mem_data
   );
endinterface

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
//
// Purpose: request-side controller in front of a K-way clock-replacement cache.
// One line-read request is accepted at a time. The cache read port is probed;
// a hit returns the cached line, a miss fetches the line from backing memory,
// writes it into the cache and then returns it. A memory timeout is returned
// to the requester as an error response with zero data.
//
// Parameters:
//   ADDR_WIDTH : line address width (matches the cache)
//   LINE_WIDTH : line data width (matches the cache)
//   TIMEOUT    : max cycles spent waiting for mem_ack; must be >= 2
//
// Ports:
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset; the cache must be reset
//                 together with this block (its sweep may be left mid-way)
//   bus         : cache_fill_ctrl_if.master (request, response, cache, memory)
//   o_dbg_state : current FSM state encoding, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE (and 0 on the first cycle
// out of reset); req_valid is ignored whenever req_ready is 0. The response is
// a single-cycle rsp_valid strobe with no ready; the requester must take it.
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int LINE_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   cache_fill_ctrl_if.master bus,
   output logic [2:0]        o_dbg_state
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_CHECK  = 3'd2,
      S_MEM    = 3'd3,
      S_FILL   = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [LINE_WIDTH-1:0] r_data;
   logic [LINE_WIDTH-1:0] w_data_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  r_err;
   logic                  w_err_nxt;
   logic                  r_fill_first;
   logic                  w_fill_first_nxt;
   logic                  r_req_ready;
   logic                  w_accept;

   // req_ready is a register rather than a decode of IDLE so that it reads 0
   // while reset is asserted and rises only on the first edge after release.
   assign w_accept = r_req_ready & bus.req_valid;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_data       <= '0;
         r_cnt        <= '0;
         r_err        <= 1'b0;
         r_fill_first <= 1'b0;
         r_req_ready  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_data       <= w_data_nxt;
         r_cnt        <= w_cnt_nxt;
         r_err        <= w_err_nxt;
         r_fill_first <= w_fill_first_nxt;
         r_req_ready  <= (w_state_nxt == S_IDLE);
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath updates
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_data_nxt       = r_data;
      w_cnt_nxt        = r_cnt;
      w_err_nxt        = r_err;
      w_fill_first_nxt = r_fill_first;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_addr_nxt  = bus.req_addr;
               w_state_nxt = S_LOOKUP;
            end
         end

         // c_read is asserted for this single cycle; the cache answers with
         // registered c_hit/c_out_val visible in CHECK.
         S_LOOKUP: begin
            w_state_nxt = S_CHECK;
         end

         S_CHECK: begin
            if (bus.c_hit) begin
               w_data_nxt  = bus.c_out_val;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_MEM;
            end
         end

         // The counter holds the number of MEM cycles already completed, so
         // leaving on CNT_LAST gives exactly TIMEOUT cycles in MEM. An ack in
         // that final cycle takes priority over the timeout.
         S_MEM: begin
            if (bus.mem_ack) begin
               w_data_nxt       = bus.mem_data;
               w_err_nxt        = 1'b0;
               w_fill_first_nxt = 1'b1;
               w_state_nxt      = S_FILL;
            end else if (r_cnt == CNT_LAST) begin
               w_data_nxt  = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         // In the first FILL cycle c_hit still carries the miss result of the
         // CHECK read, so it is not a write-done indication yet.
         S_FILL: begin
            if (r_fill_first) begin
               w_fill_first_nxt = 1'b0;
            end else if (bus.c_hit) begin
               w_err_nxt   = 1'b0;
               w_state_nxt = S_RESP;
            end
         end

         S_RESP: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from the state register or taken straight from
   // registers, so nothing combinational from the inputs reaches a port.
   // ---------------------------------------------------------------------------
   assign bus.req_ready = r_req_ready;

   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_err   = (r_state == S_RESP) & r_err;
   assign bus.rsp_data  = (r_state == S_RESP) ? r_data : '0;

   // One address register feeds both cache ports and memory; the cache only
   // looks at it when c_read or c_write is set.
   assign bus.c_addr    = r_addr;
   assign bus.c_val     = r_data;
   assign bus.c_read    = (r_state == S_LOOKUP);
   assign bus.c_write   = (r_state == S_FILL);

   assign bus.mem_req   = (r_state == S_MEM);
   assign bus.mem_addr  = r_addr;

   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
//
// Bench for cache_fill_ctrl with TIMEOUT = 8 and a 2-way clock-replacement
// cache model. Memory content is a fixed table, so every good response must
// carry the table value of its address; timeouts must carry zero data.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

   localparam int AW = 8;
   localparam int LW = 32;
   localparam int TO = 8;
   localparam int K  = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] dbg_state;

   always #5 clock = ~clock;

   cache_fill_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   cache_fill_ctrl #(
      .ADDR_WIDTH(AW),
      .LINE_WIDTH(LW),
      .TIMEOUT   (TO)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .bus        (bus.master),
      .o_dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Backing memory: fixed table, ack after ack_delay cycles of mem_req
   // (0 = never acknowledge).
   // ---------------------------------------------------------------------------
   logic [LW-1:0] mem_table [256];
   int            ack_delay = 0;
   int            mem_cnt   = 0;

   always @(negedge clock) begin
      if (bus.mem_req) begin
         mem_cnt      = mem_cnt + 1;
         bus.mem_ack  = (mem_cnt == ack_delay);
         bus.mem_data = (mem_cnt == ack_delay) ? mem_table[bus.mem_addr] : '0;
      end else begin
         mem_cnt      = 0;
         bus.mem_ack  = 1'b0;
         bus.mem_data = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // K-way clock-replacement cache model (environment). Write sweeps one way
   // per cycle; c_hit is registered.
   // ---------------------------------------------------------------------------
   logic          c_vld [K];
   logic [AW-1:0] c_tag [K];
   logic [LW-1:0] c_dat [K];
   logic          c_ref [K];
   int            c_hand;

   function automatic int find_way(input logic [AW-1:0] a);
      for (int i = 0; i < K; i++)
         if (c_vld[i] && c_tag[i] == a) return i;
      return -1;
   endfunction

   function automatic int find_free();
      for (int i = 0; i < K; i++)
         if (!c_vld[i]) return i;
      return -1;
   endfunction

   always @(posedge clock or negedge reset_n) begin : cache_model
      int w;
      if (!reset_n) begin
         for (int i = 0; i < K; i++) begin
            c_vld[i] <= 1'b0;
            c_tag[i] <= '0;
            c_dat[i] <= '0;
            c_ref[i] <= 1'b0;
         end
         c_hand        <= 0;
         bus.c_hit     <= 1'b0;
         bus.c_out_val <= '0;
      end else if (bus.c_read) begin
         w = find_way(bus.c_addr);
         if (w >= 0) begin
            bus.c_hit     <= 1'b1;
            bus.c_out_val <= c_dat[w];
            c_ref[w]      <= 1'b1;
         end else begin
            bus.c_hit     <= 1'b0;
            bus.c_out_val <= '0;
         end
      end else if (bus.c_write) begin
         w = find_way(bus.c_addr);
         if (w < 0) w = find_free();
         if (w < 0 && !c_ref[c_hand]) begin
            w = c_hand;
            c_hand <= (c_hand + 1) % K;
         end
         if (w >= 0) begin
            c_vld[w]  <= 1'b1;
            c_tag[w]  <= bus.c_addr;
            c_dat[w]  <= bus.c_val;
            c_ref[w]  <= 1'b1;
            bus.c_hit <= 1'b1;
         end else begin
            c_ref[c_hand] <= 1'b0;
            c_hand        <= (c_hand + 1) % K;
            bus.c_hit     <= 1'b0;
         end
      end else begin
         bus.c_hit <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Activity monitor: cumulative cycle counts of each strobe.
   // ---------------------------------------------------------------------------
   int n_read  = 0;
   int n_mreq  = 0;
   int n_write = 0;

   always @(negedge clock) begin
      if (bus.c_read)  n_read++;
      if (bus.mem_req) n_mreq++;
      if (bus.c_write) n_write++;
   end

   // ---------------------------------------------------------------------------
   // Driver + scoreboard for one request. Called at a negedge; returns at the
   // negedge after the response (an IDLE cycle).
   // Expected outcome: resident line -> 3-cycle hit; acked miss -> memory wait
   // of exactly `delay` cycles, fill >= 2 cycles; no ack -> TO cycles in MEM,
   // error response, no fill.
   // ---------------------------------------------------------------------------
   task automatic do_req(input string tag, input logic [AW-1:0] addr, input int delay,
                         output int o_mem, output int o_wr);
      logic [LW-1:0] exp_q [$];
      logic          exp_err;
      int            exp_mem;
      bit            exp_hit;
      int            r0, m0, w0, lat, waitc, fills;

      ack_delay = delay;
      waitc = 0;
      while (!bus.req_ready && waitc < 50) begin
         @(negedge clock);
         waitc++;
      end
      check({tag, ".ready"}, 64'(bus.req_ready), 64'd1);

      exp_hit = (find_way(addr) >= 0);
      if (exp_hit) begin
         exp_q.push_back(mem_table[addr]); exp_err = 1'b0; exp_mem = 0;
      end else if (delay >= 1 && delay <= TO) begin
         exp_q.push_back(mem_table[addr]); exp_err = 1'b0; exp_mem = delay;
      end else begin
         exp_q.push_back('0); exp_err = 1'b1; exp_mem = TO;
      end

      r0 = n_read; m0 = n_mreq; w0 = n_write;
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      @(negedge clock);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom_range(0, 255);
      lat = 1;
      while (!bus.rsp_valid && lat < 300) begin
         @(negedge clock);
         lat++;
      end
      check({tag, ".rsp_seen"}, 64'(bus.rsp_valid), 64'd1);

      o_mem = n_mreq - m0;
      o_wr  = n_write - w0;
      fills = o_wr;
      check({tag, ".data"}, 64'(bus.rsp_data), 64'(exp_q.pop_front()));
      check({tag, ".err"},  64'(bus.rsp_err), 64'(exp_err));
      check({tag, ".reads"}, 64'(n_read - r0), 64'd1);
      check({tag, ".mem_cycles"}, 64'(o_mem), 64'(exp_mem));
      if (exp_hit || exp_err) begin
         check({tag, ".writes"}, 64'(o_wr), 64'd0);
         check({tag, ".latency"}, 64'(lat), 64'(3 + exp_mem));
      end else begin
         check({tag, ".fill_min"}, 64'(o_wr >= 2), 64'd1);
         check({tag, ".latency"}, 64'(lat), 64'(2 + exp_mem + fills + 1));
      end

      @(negedge clock);
      check({tag, ".rsp_one_cycle"}, 64'(bus.rsp_valid), 64'd0);
      check({tag, ".ready_again"}, 64'(bus.req_ready), 64'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence followed by randomized traffic
   // ---------------------------------------------------------------------------
   initial begin : main
      int om, ow, waitc, d;
      logic [AW-1:0] a;

      for (int i = 0; i < 256; i++) mem_table[i] = $urandom;
      mem_table[8'h10] = 32'hDEADBEEF;
      mem_table[8'h22] = 32'h12345678;

      bus.req_valid = 1'b0;
      bus.req_addr  = '0;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst.req_ready", 64'(bus.req_ready), 64'd0);
      check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst.c_read",    64'(bus.c_read),    64'd0);
      check("rst.c_write",   64'(bus.c_write),   64'd0);
      check("rst.mem_req",   64'(bus.mem_req),   64'd0);
      check("rst.rsp_data",  64'(bus.rsp_data),  64'd0);
      check("rst.c_addr",    64'(bus.c_addr),    64'd0);
      check("rst.state",     64'(dbg_state),     64'd0);
      reset_n = 1'b1;
      #1;
      check("rel.ready_low", 64'(bus.req_ready), 64'd0);
      @(posedge clock);
      #1;
      check("rel.ready_high", 64'(bus.req_ready), 64'd1);
      @(negedge clock);

      // Pre-fill 0x10 through a miss, then hit it
      do_req("prefill10", 8'h10, 3, om, ow);
      do_req("hit10", 8'h10, 3, om, ow);
      check("hit10.no_mem", 64'(om), 64'd0);

      // Cold miss with ack in the 5th MEM cycle, then repeat hits
      do_req("cold22", 8'h22, 5, om, ow);
      check("cold22.mem5", 64'(om), 64'd5);
      do_req("rep22", 8'h22, 5, om, ow);
      check("rep22.hit", 64'(om), 64'd0);

      // Timeout and ack on the timeout boundary
      do_req("timeout30", 8'h30, 0, om, ow);
      check("timeout30.nofill", 64'(ow), 64'd0);
      do_req("edge31", 8'h31, TO, om, ow);
      check("edge31.filled", 64'(ow >= 2), 64'd1);

      // Eviction with a clean cache
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      do_req("ev01", 8'h01, 2, om, ow);
      do_req("ev02", 8'h02, 2, om, ow);
      do_req("ev03", 8'h03, 2, om, ow);
      check("ev03.sweep", 64'(ow > 2), 64'd1);
      do_req("ev01_again", 8'h01, 2, om, ow);
      check("ev01_again.miss", 64'(om), 64'd2);

      // Reset in the middle of FILL
      ack_delay = 2;
      bus.req_valid = 1'b1;
      bus.req_addr  = 8'h40;
      @(negedge clock);
      bus.req_valid = 1'b0;
      waitc = 0;
      while (!bus.c_write && waitc < 50) begin
         @(negedge clock);
         waitc++;
      end
      check("midfill.reached", 64'(bus.c_write), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midfill.c_write",   64'(bus.c_write),   64'd0);
      check("midfill.mem_req",   64'(bus.mem_req),   64'd0);
      check("midfill.rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("midfill.req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("midfill.rel_low", 64'(bus.req_ready), 64'd0);
      @(posedge clock);
      #1;
      check("midfill.rel_high", 64'(bus.req_ready), 64'd1);
      @(negedge clock);
      do_req("after_rst40", 8'h40, 2, om, ow);

      // Randomized traffic over a small address set so hits, evictions and
      // timeouts all occur
      for (int n = 0; n < 40; n++) begin
         a = 8'(8'h50 + $urandom_range(0, 5));
         d = $urandom_range(0, TO);
         do_req($sformatf("rnd%0d", n), a, d, om, ow);
         if ($urandom_range(0, 3) == 0) @(negedge clock);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
